// File: rtl/dbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_arbiter_pkg
// Summary  : Shared types for the dcache port arbiter and its in-flight tracker.
// Revision : 1.0
// ============================================================================
package dbus_arbiter_pkg;

    localparam int DCACHE_PIPE_DEPTH = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        logic        write;
    } data_memreq_t;

    typedef struct packed {
        logic [31:0] rddata;
        logic        stall;
    } data_memres_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } dbus_owner_t;

    typedef struct packed {
        logic valid;
        logic is_load;
        logic killed;
    } dbus_slot_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_LD = 2'd1,
        GRANT_ST = 2'd2
    } dbus_state_t;

endpackage
`default_nettype wire

// File: rtl/dbus_arbiter_inflight_tracker.sv
`default_nettype none
// ============================================================================
// Module   : dbus_inflight_tracker
// Summary  : Shift register of in-flight dcache slots; kills and routes responses.
// Revision : 1.0
// ============================================================================
module dbus_inflight_tracker
    import dbus_arbiter_pkg::*;
#(
    parameter int PIPE_DEPTH = DCACHE_PIPE_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        insert,
    input  logic        insert_is_load,
    input  logic [31:0] rddata,
    output logic        top_valid,
    output logic        ld_rvalid,
    output logic [31:0] ld_rddata,
    output logic        st_done
);

    localparam int c_nslot = PIPE_DEPTH - 1;

    dbus_slot_t r_slot    [c_nslot];
    dbus_slot_t w_flagged [c_nslot];
    dbus_slot_t w_ins;
    logic       w_resp;

    // Flush marks every resident load; a load inserted this cycle is born killed.
    always_comb begin
        w_flagged = r_slot;
        for (int i = 0; i < c_nslot; i++) begin
            if (flush && r_slot[i].valid && r_slot[i].is_load) begin
                w_flagged[i].killed = 1'b1;
            end
        end
    end

    assign w_ins = '{valid: insert, is_load: insert_is_load, killed: flush & insert_is_load};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_nslot; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_nslot - 1; i++) begin
                r_slot[i] <= stall ? w_flagged[i] : w_flagged[i + 1];
            end
            if (insert) begin
                r_slot[c_nslot - 1] <= w_ins;
            end else if (stall) begin
                r_slot[c_nslot - 1] <= w_flagged[c_nslot - 1];
            end else begin
                r_slot[c_nslot - 1] <= '0;
            end
        end
    end

    assign top_valid = r_slot[c_nslot - 1].valid;
    assign w_resp    = r_slot[0].valid & ~stall;
    assign ld_rvalid = w_resp & r_slot[0].is_load & ~r_slot[0].killed & ~flush;
    assign ld_rddata = ld_rvalid ? rddata : '0;
    assign st_done   = w_resp & ~r_slot[0].is_load;

endmodule
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dbus_arbiter
// Summary  : Shares the dcache port between speculative loads and store drain.
// Revision : 1.0
// ============================================================================
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int PIPE_DEPTH      = DCACHE_PIPE_DEPTH,
    parameter int MAX_LOAD_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  data_memreq_t ld_req,
    input  logic         ld_request,
    output logic         ld_ready,
    output logic         ld_rvalid,
    output logic [31:0]  ld_rddata,
    input  data_memreq_t st_req,
    input  logic         st_request,
    input  logic         st_urgent,
    output logic         st_ready,
    output logic         st_done,
    output data_memreq_t dbus_req,
    output logic         dbus_request,
    input  logic         dbus_ready,
    input  data_memres_t dbus_res
);

    localparam int                    c_streak_w   = $clog2(MAX_LOAD_STREAK + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_LOAD_STREAK);

    dbus_state_t           r_state;
    dbus_state_t           w_next_state;
    dbus_owner_t           w_owner;
    logic [c_streak_w-1:0] r_streak;
    logic                  w_grant_valid;
    logic                  w_gate;
    logic                  w_accept;
    logic                  w_top_valid;

    always_comb begin
        w_owner = NONE;
        case (r_state)
            GRANT_LD: w_owner = LOAD;
            GRANT_ST: w_owner = STORE;
            default:  w_owner = NONE;
        endcase
    end

    always_comb begin
        dbus_req      = '0;
        w_grant_valid = 1'b0;
        case (w_owner)
            LOAD: begin
                dbus_req      = ld_req;
                w_grant_valid = ~flush;
            end
            STORE: begin
                dbus_req      = st_req;
                w_grant_valid = 1'b1;
            end
            default: begin
                dbus_req      = '0;
                w_grant_valid = 1'b0;
            end
        endcase
    end

    // A stalled dcache with its entry slot still occupied cannot take a new request.
    assign w_gate       = dbus_res.stall & w_top_valid;
    assign dbus_request = w_grant_valid & ~w_gate;
    assign w_accept     = dbus_request & dbus_ready;
    assign ld_ready     = w_accept & (w_owner == LOAD);
    assign st_ready     = w_accept & (w_owner == STORE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (st_request && (st_urgent || r_streak == c_streak_max)) begin
                    w_next_state = GRANT_ST;
                end else if (ld_request && !flush) begin
                    w_next_state = GRANT_LD;
                end else if (st_request) begin
                    w_next_state = GRANT_ST;
                end
            end
            GRANT_LD: begin
                if (w_accept || flush) begin
                    w_next_state = IDLE;
                end
            end
            GRANT_ST: begin
                if (w_accept) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Counts loads that overtook a waiting store; a store grant or no waiting store resets it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (!st_request || st_ready) begin
            r_streak <= '0;
        end else if (ld_ready && r_streak != c_streak_max) begin
            r_streak <= r_streak + c_streak_w'(1);
        end
    end

    dbus_inflight_tracker #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_tracker (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stall          (dbus_res.stall),
        .insert         (w_accept),
        .insert_is_load (w_owner == LOAD),
        .rddata         (dbus_res.rddata),
        .top_valid      (w_top_valid),
        .ld_rvalid      (ld_rvalid),
        .ld_rddata      (ld_rddata),
        .st_done        (st_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_arbiter
// Summary  : Vector table, directed corner sequences and random model check.
// Revision : 1.0
// ============================================================================
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam int PD   = 3;
    localparam int MAXS = 4;

    logic         clk = 1'b0;
    logic         rst, flush, ld_request, st_request, st_urgent, dbus_ready;
    data_memreq_t ld_req, st_req, dbus_req;
    data_memres_t dbus_res;
    logic         ld_ready, ld_rvalid, st_ready, st_done, dbus_request;
    logic [31:0]  ld_rddata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.PIPE_DEPTH(PD), .MAX_LOAD_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_req(ld_req), .ld_request(ld_request), .ld_ready(ld_ready),
        .ld_rvalid(ld_rvalid), .ld_rddata(ld_rddata),
        .st_req(st_req), .st_request(st_request), .st_urgent(st_urgent),
        .st_ready(st_ready), .st_done(st_done),
        .dbus_req(dbus_req), .dbus_request(dbus_request),
        .dbus_ready(dbus_ready), .dbus_res(dbus_res)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkreq(input string name, input data_memreq_t act, input data_memreq_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // e_sel: 0 = no request on the bus, 1 = load request, 2 = store request
    task automatic chk_all(input string tag, input logic e_req, input int e_sel, input logic e_lr,
                           input logic e_sr, input logic e_lv, input logic [31:0] e_d,
                           input logic e_sd);
        data_memreq_t er;
        er = '0;
        if (e_sel == 1) er = ld_req;
        else if (e_sel == 2) er = st_req;
        chk1({tag, ".dbus_request"}, dbus_request, e_req);
        chkreq({tag, ".dbus_req"}, dbus_req, er);
        chk1({tag, ".ld_ready"}, ld_ready, e_lr);
        chk1({tag, ".st_ready"}, st_ready, e_sr);
        chk1({tag, ".ld_rvalid"}, ld_rvalid, e_lv);
        chk32({tag, ".ld_rddata"}, ld_rddata, e_d);
        chk1({tag, ".st_done"}, st_done, e_sd);
    endtask

    // iv = {rst, flush, ld_request, st_request, st_urgent, dbus_ready, stall}
    task automatic cyc(input logic [6:0] iv, input logic [31:0] d);
        @(posedge clk);
        #1;
        {rst, flush, ld_request, st_request, st_urgent, dbus_ready, dbus_res.stall} = iv;
        dbus_res.rddata = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(7'b0000000, 32'h0);
    endtask

    // ev = {dbus_request, ld_ready, st_ready, ld_rvalid, st_done}
    typedef struct {
        logic [6:0]  iv;
        logic [31:0] d;
        logic [4:0]  ev;
        int          sel;
    } vec_t;
    vec_t tbl [19];

    typedef struct {
        int ns;
        bit is_load;
        bit killed;
    } ent_t;
    ent_t q[$];

    int   m_own, m_streak, ri, first;
    logic e_req, e_lr, e_sr, e_lv, e_sd, top_occ;
    int   got[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; ld_request = 1'b0; st_request = 1'b0;
        st_urgent = 1'b0; dbus_ready = 1'b0; dbus_res = '0;
        ld_req = '{addr: 32'h0000_0100, wdata: 32'h0, strobe: 4'h0, write: 1'b0};
        st_req = '{addr: 32'h0000_0200, wdata: 32'hA5A5_0001, strobe: 4'hF, write: 1'b1};

        tbl[0]  = '{7'b0000000, 32'h0,         5'b00000, 0}; // held in reset
        tbl[1]  = '{7'b1010010, 32'h0,         5'b00000, 0}; // single load
        tbl[2]  = '{7'b1010010, 32'h0,         5'b11000, 1};
        tbl[3]  = '{7'b1000000, 32'h0,         5'b00000, 0};
        tbl[4]  = '{7'b1000000, 32'hDEADBEEF,  5'b00010, 0};
        tbl[5]  = '{7'b1001010, 32'h0,         5'b00000, 0}; // store then load interleave
        tbl[6]  = '{7'b1011010, 32'h0,         5'b10100, 2};
        tbl[7]  = '{7'b1010000, 32'h0,         5'b00000, 0};
        tbl[8]  = '{7'b1010010, 32'h11111111,  5'b11001, 1};
        tbl[9]  = '{7'b1000000, 32'h22222222,  5'b00000, 0};
        tbl[10] = '{7'b1000000, 32'h33333333,  5'b00010, 0};
        tbl[11] = '{7'b1010010, 32'h0,         5'b00000, 0}; // flush after accept
        tbl[12] = '{7'b1010010, 32'h0,         5'b11000, 1};
        tbl[13] = '{7'b1100000, 32'h0,         5'b00000, 0};
        tbl[14] = '{7'b1000000, 32'h44444444,  5'b00000, 0};
        tbl[15] = '{7'b1010000, 32'h0,         5'b00000, 0}; // flush while waiting for dcache
        tbl[16] = '{7'b1010000, 32'h0,         5'b10000, 1};
        tbl[17] = '{7'b1110000, 32'h0,         5'b00000, 1};
        tbl[18] = '{7'b1000010, 32'h0,         5'b00000, 0};

        do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].iv, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].ev[4], tbl[i].sel, tbl[i].ev[3], tbl[i].ev[2],
                    tbl[i].ev[1], tbl[i].ev[1] ? tbl[i].d : 32'h0, tbl[i].ev[0]);
        end

        // Contention: four loads per store, twice over.
        do_reset();
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            cyc(7'b1011010, 32'h0);
            if (ld_ready) got.push_back(1);
            if (st_ready) got.push_back(2);
        end
        for (int i = 0; i < 10; i++)
            chk32($sformatf("contend%0d", i), (i < got.size()) ? got[i] : 0, (i % 5 == 4) ? 2 : 1);

        cyc(7'b1000000, 32'h0);
        cyc(7'b1000000, 32'h0);
        first = 0;
        for (int c = 0; c < 6 && first == 0; c++) begin
            cyc(7'b1011110, 32'h0);
            if (ld_ready) first = 1;
            if (st_ready) first = 2;
        end
        chk32("urgent_first", first, 2);

        // Stall holding a load in slot[0] for three cycles.
        do_reset();
        cyc(7'b1010010, 32'h0);
        cyc(7'b1010010, 32'h0);
        chk1("stallA_acc", ld_ready, 1'b1);
        cyc(7'b1000010, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(7'b1000011, 32'h0BAD0000 + k);
            chk1($sformatf("stallA_hold%0d", k), ld_rvalid, 1'b0);
        end
        cyc(7'b1000010, 32'hCAFEF00D);
        chk1("stallA_rvalid", ld_rvalid, 1'b1);
        chk32("stallA_data", ld_rddata, 32'hCAFEF00D);
        cyc(7'b1000010, 32'h0);
        chk1("stallA_pulse", ld_rvalid, 1'b0);

        // Stall with the top slot occupied blocks the next request.
        cyc(7'b1010010, 32'h0);
        cyc(7'b1010010, 32'h0);
        chk1("stallB_acc1", ld_ready, 1'b1);
        cyc(7'b1010011, 32'h0);
        cyc(7'b1010011, 32'h0);
        chk1("stallB_blocked_req", dbus_request, 1'b0);
        chk1("stallB_blocked_rdy", ld_ready, 1'b0);
        cyc(7'b1010010, 32'h0);
        chk1("stallB_release_req", dbus_request, 1'b1);
        chk1("stallB_acc2", ld_ready, 1'b1);
        cyc(7'b1000010, 32'h00001234);
        chk1("stallB_rv1", ld_rvalid, 1'b1);
        chk32("stallB_d1", ld_rddata, 32'h00001234);
        cyc(7'b1000010, 32'h00005678);
        chk1("stallB_rv2", ld_rvalid, 1'b1);
        chk32("stallB_d2", ld_rddata, 32'h00005678);

        // Reset with both slots occupied.
        do_reset();
        cyc(7'b1001010, 32'h0);
        cyc(7'b1011010, 32'h0);
        chk1("rstmid_st_acc", st_ready, 1'b1);
        cyc(7'b1010010, 32'h0);
        cyc(7'b1010011, 32'h0);
        chk1("rstmid_ld_acc", ld_ready, 1'b1);
        chk1("rstmid_stalled_done", st_done, 1'b0);
        cyc(7'b0000011, 32'hFFFFFFFF);
        cyc(7'b1000010, 32'hFFFFFFFF);
        chk_all("rstmid_after", 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(7'b1000010, 32'hFFFFFFFF);
            chk1($sformatf("rstmid_rv%0d", k), ld_rvalid, 1'b0);
            chk1($sformatf("rstmid_sd%0d", k), st_done, 1'b0);
        end

        // Random traffic against a transaction-level model.
        do_reset();
        m_own = 0; m_streak = 0; q.delete();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst             = 1'b1;
            flush           = ($urandom_range(0, 9) == 0);
            st_urgent       = ($urandom_range(0, 4) == 0);
            dbus_ready      = ($urandom_range(0, 9) < 6);
            dbus_res.stall  = ($urandom_range(0, 3) == 0);
            dbus_res.rddata = $urandom();
            ld_request      = (m_own == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            st_request      = (m_own == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (m_own != 1) ld_req = '{addr: $urandom(), wdata: 32'h0, strobe: 4'h0, write: 1'b0};
            if (m_own != 2) st_req = '{addr: $urandom(), wdata: $urandom(),
                                       strobe: 4'($urandom_range(1, 15)), write: 1'b1};
            @(negedge clk);

            top_occ = 1'b0;
            ri = -1;
            foreach (q[i]) begin
                if (q[i].ns == 0) top_occ = 1'b1;
                if (!dbus_res.stall && q[i].ns == PD - 2) ri = i;
            end
            e_req = ((m_own == 1 && !flush) || m_own == 2) && !(dbus_res.stall && top_occ);
            e_lr  = (m_own == 1) && e_req && dbus_ready;
            e_sr  = (m_own == 2) && e_req && dbus_ready;
            e_lv  = (ri >= 0) && q[ri].is_load && !q[ri].killed && !flush;
            e_sd  = (ri >= 0) && !q[ri].is_load;
            chk_all($sformatf("rnd%0d", n), e_req, m_own, e_lr, e_sr, e_lv,
                    e_lv ? dbus_res.rddata : 32'h0, e_sd);

            if (flush) foreach (q[i]) if (q[i].is_load) q[i].killed = 1'b1;
            if (!dbus_res.stall) begin
                if (ri >= 0) q.delete(ri);
                foreach (q[i]) q[i].ns++;
            end
            if (e_lr || e_sr) q.push_back('{ns: 0, is_load: e_lr, killed: (flush && e_lr)});
            if (m_own == 0) begin
                if (st_request && (st_urgent || m_streak == MAXS)) m_own = 2;
                else if (ld_request && !flush) m_own = 1;
                else if (st_request) m_own = 2;
            end else if (e_lr || e_sr || (m_own == 1 && flush)) begin
                m_own = 0;
            end
            if (!st_request || e_sr) m_streak = 0;
            else if (e_lr && m_streak < MAXS) m_streak++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
